// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake, operands and result of serial_adder
//   start, a, b, cin (and sub with SERIAL_ADDER_SUB_EN) : requester -> adder
//   sum, cout, busy, done                               : adder -> requester
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;
`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input sum, cout, busy, done);
    modport slave  (input start, a, b, cin, sub, output sum, cout, busy, done);
`else
    modport master (output start, a, b, cin, input sum, cout, busy, done);
    modport slave  (input start, a, b, cin, output sum, cout, busy, done);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder cell, LSB first
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_if slave (start/a/b/cin[/sub] in, sum/cout/busy/done out)
// Define SERIAL_ADDER_SUB_EN to add the sub input (a - b - cin via two's complement).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic             c_q, c_d, cout_q, cout_d, inv_q, inv_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s, sub_in;
`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif
    assign s = a_q[0] ^ b_q[0] ^ c_q;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        inv_d   = inv_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (state_q != RUN && bus.start) begin
            // Subtract stores ~b and ~cin so the cell itself always adds.
            state_d = RUN;
            a_d     = bus.a;
            b_d     = sub_in ? ~bus.b : bus.b;
            c_d     = bus.cin ^ sub_in;
            inv_d   = sub_in;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            c_d   = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = {s, res_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = DONE;
                sum_d   = res_d;
                cout_d  = c_d ^ inv_q;
            end
        end else if (state_q != IDLE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            inv_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            inv_q   <= inv_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8)
module tb_serial_adder;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    int tests = 0;
    int fails = 0;
    logic [W:0] exp_q[$];

    function automatic logic [W:0] model(logic [W-1:0] a, logic [W-1:0] b, logic c, logic s);
        int d;
        if (s) begin
            d = int'(a) - int'(b) - int'(c);
            return {d < 0, d[W-1:0]};
        end
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        bus.a = a;
        bus.b = b;
        bus.cin = c;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = s;
`endif
        bus.start = 1'b1;
        exp_q.push_back(model(a, b, c, s));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.cout, bus.sum} !== 9'h000) begin
            fails++;
            $display("FAIL reset_result got %h want 000", {bus.cout, bus.sum});
        end
        tests++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            fails++;
            $display("FAIL reset_flags busy/done got %b want 00", {bus.busy, bus.done});
        end
        rst_n = 1'b1;
        begin
            int seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
            end
            tests++;
            if (seen != 0) begin
                fails++;
                $display("FAIL idle_no_start got %0d active cycles want 0", seen);
            end
        end
    endtask

    task automatic test_basic;
        logic [W:0] e;
        int bad = 0;
        issue(8'h0F, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL basic_busy got %0d bad cycles want 0", bad);
        end
        @(negedge clk);
        tests++;
        if ({bus.busy, bus.done} !== 2'b01) begin
            fails++;
            $display("FAIL basic_done_edge busy/done got %b want 01", {bus.busy, bus.done});
        end
        e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        tests++;
        if ({bus.cout, bus.sum} !== e) begin
            fails++;
            $display("FAIL basic_result got %h want %h", {bus.cout, bus.sum}, e);
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0 || {bus.cout, bus.sum} !== 9'h010) begin
            fails++;
            $display("FAIL basic_hold done=%b result %h want done=0 result 010", bus.done, {bus.cout, bus.sum});
        end
    endtask

    task automatic test_back_to_back;
        logic [W:0] e;
        int n;
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(20, n);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        tests++;
        if (n != 8 || {bus.cout, bus.sum} !== e) begin
            fails++;
            $display("FAIL wrap_result latency %0d result %h want 8 and %h", n, {bus.cout, bus.sum}, e);
        end
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        bus.cin = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = 1'b0;
`endif
        bus.start = 1'b1;
        exp_q.push_back(model(8'hFF, 8'hFF, 1'b1, 1'b0));
        exp_q.push_back(model(8'hFF, 8'hFF, 1'b1, 1'b0));
        @(negedge clk);
        wait_done(20, n);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        tests++;
        if (n != 8 || {bus.cout, bus.sum} !== e) begin
            fails++;
            $display("FAIL b2b_first latency %0d result %h want 8 and %h", n, {bus.cout, bus.sum}, e);
        end
        @(negedge clk);
        n = 1;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        tests++;
        if (n != 9 || {bus.cout, bus.sum} !== e) begin
            fails++;
            $display("FAIL b2b_second spacing %0d result %h want 9 and %h", n, {bus.cout, bus.sum}, e);
        end
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            fails++;
            $display("FAIL b2b_release busy/done got %b want 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_ignore_start;
        logic [W:0] e;
        int n;
        int extra = 0;
        issue(8'h01, 8'h01, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        bus.a = 8'hAA;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(20, n);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        tests++;
        if (n != 5 || {bus.cout, bus.sum} !== e) begin
            fails++;
            $display("FAIL ignore_result wait %0d result %h want 5 and %h", n, {bus.cout, bus.sum}, e);
        end
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL ignore_extra_done got %0d want 0", extra);
        end
    endtask

    task automatic test_async_reset;
        int seen = 0;
        issue(8'h55, 8'h55, 1'b0, 1'b0);
        void'(exp_q.pop_back());
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.cout, bus.sum, bus.busy, bus.done} !== 11'h000) begin
            fails++;
            $display("FAIL async_reset cout/sum/busy/done got %h want 000", {bus.cout, bus.sum, bus.busy, bus.done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        tests++;
        if (seen != 0 || {bus.cout, bus.sum} !== 9'h000) begin
            fails++;
            $display("FAIL after_reset active %0d result %h want 0 and 000", seen, {bus.cout, bus.sum});
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        logic [W:0] e;
        int n;
        issue(8'h00, 8'h01, 1'b0, 1'b1);
        wait_done(20, n);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        tests++;
        if ({bus.cout, bus.sum} !== 9'h1FF || e !== 9'h1FF) begin
            fails++;
            $display("FAIL sub_borrow got %h model %h want 1ff", {bus.cout, bus.sum}, e);
        end
        issue(8'h05, 8'h03, 1'b1, 1'b1);
        wait_done(20, n);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        tests++;
        if ({bus.cout, bus.sum} !== 9'h001 || e !== 9'h001) begin
            fails++;
            $display("FAIL sub_plain got %h model %h want 001", {bus.cout, bus.sum}, e);
        end
    endtask
`endif

    task automatic test_random;
        logic [W:0] e, prev;
        logic [W-1:0] a, b;
        logic c, s;
        int n;
        bit stable;
        for (int k = 0; k < 1000; k++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            repeat ($urandom_range(0, 2)) @(negedge clk);
            prev = {bus.cout, bus.sum};
            issue(a, b, c, s);
            stable = 1'b1;
            n = 0;
            while (bus.done !== 1'b1 && n < 20) begin
                if ({bus.cout, bus.sum} !== prev) stable = 1'b0;
                @(negedge clk);
                n++;
            end
            e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
            tests++;
            if (n != 8 || {bus.cout, bus.sum} !== e) begin
                fails++;
                $display("FAIL rand_%0d a=%h b=%h cin=%b sub=%b latency %0d result %h want 8 and %h", k, a, b, c, s, n, {bus.cout, bus.sum}, e);
            end
            tests++;
            if (!stable) begin
                fails++;
                $display("FAIL rand_stable_%0d result moved before done want held %h", k, prev);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = 1'b0;
`endif
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_async_reset();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
